// File: rtl/trigger_seq_ctrl.sv
// trigger_seq_ctrl: sequencing controller for the trigger_gen time-of-flight
// datapath (rxclk domain). Owns trig_enable and the trigger_gen configuration,
// latches configuration only while the datapath is disabled (LOAD), detects the
// final TRIGGER event, captures pulse_tof, re-arms for multi-shot runs and
// supervises each armed period with a timeout.
//
// Ports:
//   rxclk, adc_rst               clock, async active-high reset
//   cfg_arm / cfg_abort          one-cycle run start / immediate stop
//   cfg_auto_rearm, cfg_shots    multi-shot control (cfg_shots 0 = unlimited)
//   cfg_timeout, cfg_holdoff     ARMED cycle limit (0 = off), disabled gap
//   cfg_level_*, cfg_param_*     shadow configuration, latched in LOAD
//   trig_enable, trig_level_*,
//   param_mul, param_off         registered drive to trigger_gen
//   detect_pls_0/1, pulse_tof    status from trigger_gen
//   tof_capture, tof_valid       captured time of flight + one-cycle strobe
//   shot_count, busy,
//   timeout_flag                 run status (timeout_flag sticky until arm)
module trigger_seq_ctrl #(
  parameter int unsigned SHOT_WIDTH  = 16,
  parameter int unsigned CNT_WIDTH   = 32,
  parameter int unsigned MIN_HOLDOFF = 2
) (
  input  logic                  rxclk,
  input  logic                  adc_rst,
  input  logic                  cfg_arm,
  input  logic                  cfg_abort,
  input  logic                  cfg_auto_rearm,
  input  logic [SHOT_WIDTH-1:0] cfg_shots,
  input  logic [CNT_WIDTH-1:0]  cfg_timeout,
  input  logic [CNT_WIDTH-1:0]  cfg_holdoff,
  input  logic [31:0]           cfg_level_a,
  input  logic [31:0]           cfg_level_b,
  input  logic [31:0]           cfg_level_c,
  input  logic [31:0]           cfg_param_mul,
  input  logic [31:0]           cfg_param_off,
  output logic                  trig_enable,
  output logic [31:0]           trig_level_a,
  output logic [31:0]           trig_level_b,
  output logic [31:0]           trig_level_c,
  output logic [31:0]           param_mul,
  output logic [31:0]           param_off,
  input  logic                  detect_pls_0,
  input  logic                  detect_pls_1,
  input  logic [31:0]           pulse_tof,
  output logic [31:0]           tof_capture,
  output logic                  tof_valid,
  output logic [SHOT_WIDTH-1:0] shot_count,
  output logic                  busy,
  output logic                  timeout_flag
);

  localparam int unsigned SW1 = SHOT_WIDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_ARMED   = 3'd2,
    S_HOLDOFF = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t                state, state_d;
  logic                  pls1_d;
  logic [CNT_WIDTH-1:0]  tmo_cnt, hold_cnt;
  logic [CNT_WIDTH-1:0]  hold_len;
  logic                  trig_event, tmo_hit, hold_done, more_shots;
  logic                  capture, arm_accept, tmo_set;
  logic [SW1-1:0]        shot_inc;
  logic [SHOT_WIDTH-1:0] shot_sat;

  // Event, timeout, holdoff and shot-limit decode
  always_comb begin
    trig_event = (state == S_ARMED) && pls1_d && !detect_pls_1 && detect_pls_0;
    tmo_hit    = (cfg_timeout != '0) && (tmo_cnt == cfg_timeout - CNT_WIDTH'(1));
    hold_len   = (cfg_holdoff > CNT_WIDTH'(MIN_HOLDOFF)) ? cfg_holdoff
                                                         : CNT_WIDTH'(MIN_HOLDOFF);
    hold_done  = (hold_cnt == hold_len - CNT_WIDTH'(1));
    shot_inc   = {1'b0, shot_count} + SW1'(1);
    // Carry out means shot_count is all-ones: hold it there
    shot_sat   = shot_inc[SHOT_WIDTH] ? shot_count : shot_inc[SHOT_WIDTH-1:0];
    more_shots = cfg_auto_rearm &&
                 ((cfg_shots == '0) || (shot_inc < {1'b0, cfg_shots}));
  end

  // State register
  always_ff @(posedge rxclk or posedge adc_rst) begin
    if (adc_rst) state <= S_IDLE;
    else         state <= state_d;
  end

  // Next state and per-cycle actions; abort overrides everything
  always_comb begin
    state_d    = state;
    capture    = 1'b0;
    arm_accept = 1'b0;
    tmo_set    = 1'b0;
    case (state)
      S_IDLE: begin
        if (cfg_arm) begin
          state_d    = S_LOAD;
          arm_accept = 1'b1;
        end
      end
      S_LOAD: state_d = S_ARMED;
      S_ARMED: begin
        if (trig_event) begin
          capture = 1'b1;
          state_d = more_shots ? S_HOLDOFF : S_DONE;
        end else if (tmo_hit) begin
          tmo_set = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_HOLDOFF: begin
        if (hold_done) state_d = S_LOAD;
      end
      S_DONE: begin
        if (cfg_arm) begin
          state_d    = S_LOAD;
          arm_accept = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (cfg_abort) begin
      state_d    = S_IDLE;
      capture    = 1'b0;
      arm_accept = 1'b0;
      tmo_set    = 1'b0;
    end
  end

  // Registered outputs and internal counters; enable/busy follow the next state
  always_ff @(posedge rxclk or posedge adc_rst) begin
    if (adc_rst) begin
      trig_enable  <= 1'b0;
      busy         <= 1'b0;
      tof_valid    <= 1'b0;
      tof_capture  <= '0;
      shot_count   <= '0;
      timeout_flag <= 1'b0;
      trig_level_a <= '0;
      trig_level_b <= '0;
      trig_level_c <= '0;
      param_mul    <= '0;
      param_off    <= '0;
      pls1_d       <= 1'b0;
      tmo_cnt      <= '0;
      hold_cnt     <= '0;
    end else begin
      trig_enable <= (state_d == S_ARMED) || (state_d == S_DONE);
      busy        <= (state_d == S_LOAD) || (state_d == S_ARMED) ||
                     (state_d == S_HOLDOFF);
      tof_valid   <= capture;
      pls1_d      <= (state == S_ARMED) && detect_pls_1;
      // Counters run only in their own state and saturate instead of wrapping
      tmo_cnt     <= (state != S_ARMED) ? '0 :
                     ((&tmo_cnt) ? tmo_cnt : tmo_cnt + CNT_WIDTH'(1));
      hold_cnt    <= (state != S_HOLDOFF) ? '0 :
                     ((&hold_cnt) ? hold_cnt : hold_cnt + CNT_WIDTH'(1));
      if (capture) begin
        tof_capture <= pulse_tof;
        shot_count  <= shot_sat;
      end
      if (arm_accept) begin
        shot_count   <= '0;
        timeout_flag <= 1'b0;
      end
      if (tmo_set) timeout_flag <= 1'b1;
      // Shadow config is latched only on entry to LOAD, while enable is low
      if (state_d == S_LOAD) begin
        trig_level_a <= cfg_level_a;
        trig_level_b <= cfg_level_b;
        trig_level_c <= cfg_level_c;
        param_mul    <= cfg_param_mul;
        param_off    <= cfg_param_off;
      end
    end
  end

endmodule

// File: tb/tb_trigger_seq_ctrl.sv
// Self-checking bench for trigger_seq_ctrl: randomized runs driven by a small
// trigger_gen stand-in, checked against transaction-level expectations.
module tb_trigger_seq_ctrl;

  localparam int unsigned SW      = 4;
  localparam int unsigned CW      = 32;
  localparam int unsigned SAT_MAX = (1 << SW) - 1;

  logic          rxclk, adc_rst;
  logic          cfg_arm, cfg_abort, cfg_auto_rearm;
  logic [SW-1:0] cfg_shots;
  logic [CW-1:0] cfg_timeout, cfg_holdoff;
  logic [31:0]   cfg_level_a, cfg_level_b, cfg_level_c, cfg_param_mul, cfg_param_off;
  logic          trig_enable;
  logic [31:0]   trig_level_a, trig_level_b, trig_level_c, param_mul, param_off;
  logic          detect_pls_0, detect_pls_1;
  logic [31:0]   pulse_tof, tof_capture;
  logic          tof_valid, busy, timeout_flag;
  logic [SW-1:0] shot_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] lat_a, lat_b, lat_c, lat_mul, lat_off;
  logic [31:0] last_tof;

  trigger_seq_ctrl #(.SHOT_WIDTH(SW), .CNT_WIDTH(CW), .MIN_HOLDOFF(2)) dut (
    .rxclk(rxclk), .adc_rst(adc_rst),
    .cfg_arm(cfg_arm), .cfg_abort(cfg_abort), .cfg_auto_rearm(cfg_auto_rearm),
    .cfg_shots(cfg_shots), .cfg_timeout(cfg_timeout), .cfg_holdoff(cfg_holdoff),
    .cfg_level_a(cfg_level_a), .cfg_level_b(cfg_level_b), .cfg_level_c(cfg_level_c),
    .cfg_param_mul(cfg_param_mul), .cfg_param_off(cfg_param_off),
    .trig_enable(trig_enable),
    .trig_level_a(trig_level_a), .trig_level_b(trig_level_b), .trig_level_c(trig_level_c),
    .param_mul(param_mul), .param_off(param_off),
    .detect_pls_0(detect_pls_0), .detect_pls_1(detect_pls_1), .pulse_tof(pulse_tof),
    .tof_capture(tof_capture), .tof_valid(tof_valid), .shot_count(shot_count),
    .busy(busy), .timeout_flag(timeout_flag)
  );

  initial begin
    rxclk = 1'b0;
    forever #4 rxclk = ~rxclk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Disabled cycles between shots: holdoff (min 2) plus the LOAD cycle
  function automatic int exp_gap(input logic [31:0] h);
    return ((h > 32'd2) ? int'(h) : 2) + 1;
  endfunction

  task automatic latch_model();
    lat_a = cfg_level_a; lat_b = cfg_level_b; lat_c = cfg_level_c;
    lat_mul = cfg_param_mul; lat_off = cfg_param_off;
  endtask

  task automatic set_cfg_random();
    cfg_level_a = $urandom; cfg_level_b = $urandom; cfg_level_c = $urandom;
    cfg_param_mul = $urandom; cfg_param_off = $urandom;
  endtask

  // All tasks enter and leave on a falling edge
  task automatic do_arm();
    cfg_arm = 1'b1;
    @(negedge rxclk);
    cfg_arm = 1'b0;
  endtask

  task automatic wait_enable();
    for (int i = 0; i < 50; i++) begin
      if (trig_enable) break;
      @(negedge rxclk);
    end
    check("wait_enable", trig_enable, 1);
  endtask

  // trigger_gen stand-in: detect_pls_1 high one cycle, then falls with pls_0 high
  task automatic fire(input logic [31:0] tof, input bit abort_too);
    detect_pls_0 = 1'b1;
    detect_pls_1 = 1'b1;
    @(negedge rxclk);
    detect_pls_1 = 1'b0;
    pulse_tof    = tof;
    cfg_abort    = abort_too;
    @(negedge rxclk);
    cfg_abort    = 1'b0;
    detect_pls_0 = 1'b0;
  endtask

  task automatic run_shots(input int n_fire, input bit final_done, input logic [31:0] tof0);
    int gap, extra, exp_cnt;
    logic [31:0] tof;
    do_arm();
    check("arm_cnt_clr", shot_count, 0);
    check("arm_flag_clr", timeout_flag, 0);
    check("load_busy", busy, 1);
    check("load_en", trig_enable, 0);
    latch_model();
    for (int k = 1; k <= n_fire; k++) begin
      wait_enable();
      check("lat_a", trig_level_a, lat_a);
      check("lat_b", trig_level_b, lat_b);
      check("lat_c", trig_level_c, lat_c);
      check("lat_mul", param_mul, lat_mul);
      check("lat_off", param_off, lat_off);
      if (k == 1) begin
        cfg_param_mul = $urandom;
        cfg_level_b   = $urandom;
        @(negedge rxclk);
        check("frozen_mul", param_mul, lat_mul);
        check("frozen_b", trig_level_b, lat_b);
      end
      repeat ($urandom_range(0, 3)) @(negedge rxclk);
      tof = (k == 1 && tof0 != 0) ? tof0 : $urandom;
      fire(tof, 1'b0);
      exp_cnt = (k > int'(SAT_MAX)) ? int'(SAT_MAX) : k;
      check("tof_valid", tof_valid, 1);
      check("tof_capture", tof_capture, tof);
      check("shot_count", shot_count, exp_cnt);
      last_tof  = tof;
      pulse_tof = $urandom;
      if (k < n_fire || !final_done) begin
        latch_model();
        check("holdoff_busy", busy, 1);
        gap = 0;
        extra = 0;
        while (!trig_enable && gap < 200) begin
          if (gap > 0 && tof_valid) extra++;
          gap++;
          @(negedge rxclk);
        end
        check("gap", gap, exp_gap(cfg_holdoff));
        check("valid_once", extra, 0);
      end else begin
        check("done_en", trig_enable, 1);
        check("done_busy", busy, 0);
        @(negedge rxclk);
        check("valid_once", tof_valid, 0);
        repeat (3) @(negedge rxclk);
        check("done_hold_en", trig_enable, 1);
        check("done_capture", tof_capture, tof);
      end
    end
  endtask

  initial begin
    int hi, nv, ne;
    logic [31:0] tof;
    adc_rst = 1'b1;
    cfg_arm = 1'b0; cfg_abort = 1'b0; cfg_auto_rearm = 1'b0;
    cfg_shots = '0; cfg_timeout = '0; cfg_holdoff = '0;
    set_cfg_random();
    detect_pls_0 = 1'b0; detect_pls_1 = 1'b0; pulse_tof = '0;
    last_tof = '0;
    repeat (2) @(negedge rxclk);
    check("rst_en", trig_enable, 0);
    check("rst_busy", busy, 0);
    check("rst_capture", tof_capture, 0);
    check("rst_cnt", shot_count, 0);
    check("rst_mul", param_mul, 0);
    check("rst_valid", tof_valid, 0);
    adc_rst = 1'b0;
    @(negedge rxclk);

    // Single shot, no re-arm
    cfg_level_a = 32'h0100FF00;
    cfg_auto_rearm = 1'b0; cfg_shots = SW'(1);
    run_shots(1, 1'b1, 32'h1234);

    // Three shots with a 10-cycle holdoff
    cfg_auto_rearm = 1'b1; cfg_shots = SW'(3); cfg_holdoff = 32'd10;
    run_shots(3, 1'b1, 32'h0);

    // Randomized runs
    for (int r = 0; r < 6; r++) begin
      set_cfg_random();
      cfg_auto_rearm = 1'($urandom_range(0, 1));
      cfg_shots      = SW'($urandom_range(1, 4));
      cfg_holdoff    = $urandom_range(0, 12);
      run_shots(cfg_auto_rearm ? int'(cfg_shots) : 1, 1'b1, 32'h0);
    end

    // Unlimited run past shot_count saturation, then abort
    cfg_auto_rearm = 1'b1; cfg_shots = '0; cfg_holdoff = '0;
    run_shots(int'(SAT_MAX) + 3, 1'b0, 32'h0);
    cfg_abort = 1'b1;
    @(negedge rxclk);
    cfg_abort = 1'b0;
    check("abort_en", trig_enable, 0);
    check("abort_sat_cnt", shot_count, SAT_MAX);
    check("abort_capture", tof_capture, last_tof);

    // Timeout after 100 armed cycles
    cfg_auto_rearm = 1'b0; cfg_shots = SW'(1); cfg_timeout = 32'd100;
    do_arm();
    wait_enable();
    hi = 0;
    while (trig_enable && hi < 300) begin
      hi++;
      @(negedge rxclk);
    end
    check("tmo_cycles", hi, 100);
    check("tmo_flag", timeout_flag, 1);
    check("tmo_busy", busy, 0);
    repeat (5) @(negedge rxclk);
    check("tmo_sticky", timeout_flag, 1);
    check("tmo_idle_en", trig_enable, 0);
    do_arm();
    check("arm_clr_flag", timeout_flag, 0);
    cfg_abort = 1'b1;
    @(negedge rxclk);
    cfg_abort = 1'b0;
    check("abort_load_en", trig_enable, 0);
    check("abort_load_busy", busy, 0);

    // Trigger event on the timeout cycle wins
    cfg_timeout = 32'd20;
    do_arm();
    wait_enable();
    repeat (18) @(negedge rxclk);
    tof = $urandom;
    fire(tof, 1'b0);
    check("coll_valid", tof_valid, 1);
    check("coll_capture", tof_capture, tof);
    check("coll_flag", timeout_flag, 0);
    check("coll_done_en", trig_enable, 1);
    last_tof = tof;
    repeat (25) @(negedge rxclk);
    check("coll_flag_late", timeout_flag, 0);
    cfg_timeout = '0;

    // Abort in the same cycle as an event: no capture
    do_arm();
    wait_enable();
    repeat (2) @(negedge rxclk);
    fire($urandom, 1'b1);
    check("abev_valid", tof_valid, 0);
    check("abev_en", trig_enable, 0);
    check("abev_busy", busy, 0);
    check("abev_capture", tof_capture, last_tof);
    check("abev_cnt", shot_count, 0);

    // Asynchronous reset between clock edges while ARMED
    cfg_auto_rearm = 1'b1; cfg_shots = '0;
    do_arm();
    wait_enable();
    repeat (3) @(negedge rxclk);
    #2 adc_rst = 1'b1;
    #1;
    check("arst_en", trig_enable, 0);
    check("arst_busy", busy, 0);
    check("arst_capture", tof_capture, 0);
    check("arst_mul", param_mul, 0);
    check("arst_level_a", trig_level_a, 0);
    @(negedge rxclk);
    adc_rst = 1'b0;
    nv = 0;
    ne = 0;
    for (int i = 0; i < 8; i++) begin
      detect_pls_0 = 1'b1;
      detect_pls_1 = (i % 2 == 0);
      @(negedge rxclk);
      if (tof_valid) nv++;
      if (trig_enable) ne++;
    end
    detect_pls_0 = 1'b0;
    detect_pls_1 = 1'b0;
    check("arst_no_valid", nv, 0);
    check("arst_no_en", ne, 0);
    check("arst_cnt", shot_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/trigger_seq_ctrl.md
Name: trigger_seq_ctrl

Overview:
- Sequencing controller for the trigger_gen time-of-flight datapath, same rxclk (125 MHz) domain.
- Owns trig_enable and all trigger_gen configuration inputs. Loads configuration atomically, only while the datapath is disabled.
- Detects trigger_gen's final TRIGGER event, captures pulse_tof, and optionally re-arms for a programmed number of shots.
- Supervises each armed period with a timeout.

Parameters:
- SHOT_WIDTH, 16, width of the shot counter and cfg_shots.
- CNT_WIDTH, 32, width of the timeout and holdoff counters.
- MIN_HOLDOFF, 2, minimum number of disabled cycles between shots.

Ports:
- rxclk  in  1  ADC-side clock, 125 MHz.
- adc_rst  in  1  asynchronous active-high reset.
- cfg_arm  in  1  one-cycle pulse; starts a run.
- cfg_abort  in  1  one-cycle pulse; stops immediately.
- cfg_auto_rearm  in  1  1 = re-arm after each captured shot.
- cfg_shots  in  SHOT_WIDTH  shots per run; 0 = unlimited.
- cfg_timeout  in  CNT_WIDTH  cycles allowed in ARMED; 0 = disabled.
- cfg_holdoff  in  CNT_WIDTH  disabled cycles between shots.
- cfg_level_a / cfg_level_b / cfg_level_c  in  32 each  shadow trigger levels.
- cfg_param_mul / cfg_param_off  in  32 each  shadow delay parameters.
- trig_enable  out  1  to trigger_gen.
- trig_level_a / trig_level_b / trig_level_c  out  32 each  latched levels to trigger_gen.
- param_mul / param_off  out  32 each  latched parameters to trigger_gen.
- detect_pls_0 / detect_pls_1  in  1 each  from trigger_gen.
- pulse_tof  in  32  from trigger_gen.
- tof_capture  out  32  pulse_tof value captured at the trigger event.
- tof_valid  out  1  one-cycle strobe qualifying tof_capture.
- shot_count  out  SHOT_WIDTH  shots captured in the current run.
- busy  out  1  high in LOAD, ARMED, HOLDOFF.
- timeout_flag  out  1  sticky; cleared by cfg_arm.

Behaviour:
- Reset values (asynchronous): every output 0; state IDLE; all internal counters 0; pls1_d = 0.
- States: IDLE, LOAD, ARMED, HOLDOFF, DONE. All outputs are registered.
- IDLE:
  - trig_enable = 0.
  - cfg_arm -> LOAD. Clears shot_count and timeout_flag.
- LOAD (exactly 1 cycle):
  - trig_enable = 0.
  - Copies all cfg_level_*/cfg_param_* to the outputs.
  - Clears the timeout counter and pls1_d.
  - -> ARMED.
- ARMED:
  - trig_enable = 1; timeout counter increments each cycle.
  - Output config registers are frozen; cfg_* changes take effect only at the next LOAD.
  - pls1_d = detect_pls_1 registered.
  - Trigger event = pls1_d & ~detect_pls_1 & detect_pls_0.
  - On event:
    - tof_capture <= pulse_tof; tof_valid = 1 for the next cycle only.
    - shot_count <= shot_count + 1, saturating at all-ones.
    - If cfg_auto_rearm and (cfg_shots == 0 or shot_count+1 < cfg_shots) -> HOLDOFF; else -> DONE.
  - Timeout: cfg_timeout != 0 and counter == cfg_timeout-1 -> timeout_flag <= 1, -> IDLE.
  - Note: trigger_gen has a 12.5M-cycle internal idle after enable, so software programs cfg_timeout > 12_500_000.
- HOLDOFF:
  - trig_enable = 0 for max(cfg_holdoff, MIN_HOLDOFF) cycles.
  - Detect inputs are ignored.
  - -> LOAD, which re-latches cfg_*; parameters may change between shots.
- DONE:
  - trig_enable stays 1, so trigger_gen holds its TRIGGER outputs.
  - cfg_arm -> LOAD (new run; shot_count cleared). The LOAD cycle drops enable, resetting trigger_gen.
- Priority:
  - cfg_abort overrides everything: -> IDLE, trig_enable 0 next cycle, no capture. tof_capture and shot_count hold their values.
  - Trigger event and timeout in the same cycle: the trigger event wins; timeout_flag is not set.
  - cfg_arm while in LOAD, ARMED or HOLDOFF is ignored.
  - cfg_arm and cfg_abort in the same cycle: abort wins.
- Counter boundaries:
  - Timeout and holdoff counters never wrap; comparison is by equality.
  - shot_count saturates at 2^SHOT_WIDTH-1. With cfg_shots = 0 and auto re-arm, the run continues after saturation.
- Reset mid-operation: outputs return to 0 immediately; trig_enable low disables trigger_gen.

Test Plan:
1. Single shot: cfg_arm with auto_rearm=0, cfg_level_a=0x0100FF00; model trigger_gen drops detect_pls_1 with detect_pls_0=1 and pulse_tof=0x1234 -> tof_valid pulses once, tof_capture=0x1234, shot_count=1, state DONE, trig_enable stays 1.
2. Multi-shot: auto_rearm=1, cfg_shots=3, cfg_holdoff=10 -> three captures; trig_enable low exactly 10 cycles plus 1 LOAD cycle between shots; ends in DONE with shot_count=3.
3. Timeout: cfg_timeout=100, no event -> timeout_flag=1 at cycle 100 of ARMED, trig_enable=0, state IDLE; next cfg_arm clears the flag.
4. Atomic config: change cfg_param_mul while ARMED -> param_mul unchanged until the next LOAD; new value appears on the first HOLDOFF->LOAD.
5. Collisions: trigger event on the timeout cycle -> capture, no timeout_flag. cfg_abort with an event in the same cycle -> no tof_valid, IDLE.
6. Async reset asserted mid-ARMED between clock edges -> all outputs 0 immediately; no tof_valid after release.
